// File: rtl/rs_entry_array_if.sv
// rs_entry_array_if: dispatch, wakeup, issue and status signals of the reservation-station entry array.
interface rs_entry_array_if #(
  parameter int RS_SIZE = 4,
  parameter int RS_INDEX_WIDTH = 2,
  parameter int TAG_WIDTH = 6,
  parameter int PAYLOAD_WIDTH = 64
);
  logic                      flush_i;
  logic                      wr_first_en_i;
  logic [RS_INDEX_WIDTH-1:0] wr_rs_index_first_i;
  logic [TAG_WIDTH-1:0]      wr_first_src1_tag_i, wr_first_src2_tag_i;
  logic                      wr_first_src1_rdy_i, wr_first_src2_rdy_i;
  logic [PAYLOAD_WIDTH-1:0]  wr_first_payload_i;
  logic                      wr_second_en_i;
  logic [RS_INDEX_WIDTH-1:0] wr_rs_index_second_i;
  logic [TAG_WIDTH-1:0]      wr_second_src1_tag_i, wr_second_src2_tag_i;
  logic                      wr_second_src1_rdy_i, wr_second_src2_rdy_i;
  logic [PAYLOAD_WIDTH-1:0]  wr_second_payload_i;
  logic                      wakeup_valid_i;
  logic [TAG_WIDTH-1:0]      wakeup_tag_i;
  logic [RS_SIZE-1:0]        rs_unused_o;
  logic                      issue_valid_o;
  logic                      issue_ready_i;
  logic [RS_INDEX_WIDTH-1:0] issue_index_o;
  logic [PAYLOAD_WIDTH-1:0]  issue_payload_o;
  logic [TAG_WIDTH-1:0]      issue_src1_tag_o, issue_src2_tag_o;
  logic [RS_INDEX_WIDTH:0]   rs_count_o;
  modport master (
    output flush_i, wr_first_en_i, wr_rs_index_first_i, wr_first_src1_tag_i, wr_first_src2_tag_i,
           wr_first_src1_rdy_i, wr_first_src2_rdy_i, wr_first_payload_i,
           wr_second_en_i, wr_rs_index_second_i, wr_second_src1_tag_i, wr_second_src2_tag_i,
           wr_second_src1_rdy_i, wr_second_src2_rdy_i, wr_second_payload_i,
           wakeup_valid_i, wakeup_tag_i, issue_ready_i,
    input  rs_unused_o, issue_valid_o, issue_index_o, issue_payload_o,
           issue_src1_tag_o, issue_src2_tag_o, rs_count_o
  );
  modport slave (
    input  flush_i, wr_first_en_i, wr_rs_index_first_i, wr_first_src1_tag_i, wr_first_src2_tag_i,
           wr_first_src1_rdy_i, wr_first_src2_rdy_i, wr_first_payload_i,
           wr_second_en_i, wr_rs_index_second_i, wr_second_src1_tag_i, wr_second_src2_tag_i,
           wr_second_src1_rdy_i, wr_second_src2_rdy_i, wr_second_payload_i,
           wakeup_valid_i, wakeup_tag_i, issue_ready_i,
    output rs_unused_o, issue_valid_o, issue_index_o, issue_payload_o,
           issue_src1_tag_o, issue_src2_tag_o, rs_count_o
  );
endinterface

// File: rtl/rs_entry_array.sv
// rs_entry_array: dual-dispatch reservation-station storage with tag wakeup and single issue.
// Define RS_AGE_ORDER_EN to issue the oldest ready entry instead of the lowest-index one.
module rs_entry_array #(
  parameter int RS_SIZE = 4,
  parameter int RS_INDEX_WIDTH = 2,
  parameter int TAG_WIDTH = 6,
  parameter int PAYLOAD_WIDTH = 64
) (
  input logic          clk,
  input logic          rst,
  rs_entry_array_if.slave b
);
  localparam int CW = RS_INDEX_WIDTH + 1;
  logic [RS_SIZE-1:0]        valid_q, valid_d, s1_q, s1_d, s2_q, s2_d, ready, pick;
  logic [TAG_WIDTH-1:0]      t1_q [RS_SIZE], t1_d [RS_SIZE], t2_q [RS_SIZE], t2_d [RS_SIZE];
  logic [PAYLOAD_WIDTH-1:0]  pl_q [RS_SIZE], pl_d [RS_SIZE];
  logic [CW-1:0]             count_q, count_d;
  logic [RS_INDEX_WIDTH-1:0] sel, i0, i1;
  logic                      fire;
  assign i0 = b.wr_rs_index_first_i;
  assign i1 = b.wr_rs_index_second_i;
  assign ready = valid_q & s1_q & s2_q;
  assign fire = b.issue_valid_o & b.issue_ready_i;
`ifdef RS_AGE_ORDER_EN
  // older_q[i][j] set means entry j was dispatched before entry i
  logic [RS_SIZE-1:0] older_q [RS_SIZE], older_d [RS_SIZE];
  always_comb begin
    older_d = older_q;
    for (int j = 0; j < RS_SIZE; j++) begin
      if (b.wr_first_en_i) older_d[j][i0] = 1'b0;
      if (b.wr_second_en_i) older_d[j][i1] = 1'b0;
    end
    if (b.wr_first_en_i) older_d[i0] = valid_q;
    if (b.wr_second_en_i) older_d[i1] = valid_q | (b.wr_first_en_i ? RS_SIZE'(1) << i0 : '0);
  end
  always_ff @(posedge clk) older_q <= older_d;
  always_comb begin
    pick = '0;
    for (int i = 0; i < RS_SIZE; i++) pick[i] = ready[i] & ~|(older_q[i] & ready);
  end
`else
  assign pick = ready;
`endif
  always_comb begin
    sel = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) if (pick[i]) sel = RS_INDEX_WIDTH'(i);
  end
  always_comb begin
    valid_d = valid_q;
    s1_d = s1_q;
    s2_d = s2_q;
    t1_d = t1_q;
    t2_d = t2_q;
    pl_d = pl_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      s1_d[i] = s1_q[i] | (b.wakeup_valid_i & valid_q[i] & (t1_q[i] == b.wakeup_tag_i));
      s2_d[i] = s2_q[i] | (b.wakeup_valid_i & valid_q[i] & (t2_q[i] == b.wakeup_tag_i));
    end
    if (fire) valid_d[sel] = 1'b0;
    if (b.wr_first_en_i) begin
      valid_d[i0] = 1'b1;
      t1_d[i0] = b.wr_first_src1_tag_i;
      t2_d[i0] = b.wr_first_src2_tag_i;
      pl_d[i0] = b.wr_first_payload_i;
      s1_d[i0] = b.wr_first_src1_rdy_i | (b.wakeup_valid_i & (b.wr_first_src1_tag_i == b.wakeup_tag_i));
      s2_d[i0] = b.wr_first_src2_rdy_i | (b.wakeup_valid_i & (b.wr_first_src2_tag_i == b.wakeup_tag_i));
    end
    if (b.wr_second_en_i) begin
      valid_d[i1] = 1'b1;
      t1_d[i1] = b.wr_second_src1_tag_i;
      t2_d[i1] = b.wr_second_src2_tag_i;
      pl_d[i1] = b.wr_second_payload_i;
      s1_d[i1] = b.wr_second_src1_rdy_i | (b.wakeup_valid_i & (b.wr_second_src1_tag_i == b.wakeup_tag_i));
      s2_d[i1] = b.wr_second_src2_rdy_i | (b.wakeup_valid_i & (b.wr_second_src2_tag_i == b.wakeup_tag_i));
    end
    if (b.flush_i) valid_d = '0;
  end
  assign count_d = b.flush_i ? '0 : count_q + CW'(b.wr_first_en_i) + CW'(b.wr_second_en_i) - CW'(fire);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
    s1_q <= s1_d;
    s2_q <= s2_d;
    t1_q <= t1_d;
    t2_q <= t2_d;
    pl_q <= pl_d;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      assert (!(b.wr_first_en_i && valid_q[i0]));
      assert (!(b.wr_second_en_i && valid_q[i1]));
      assert (!(b.wr_first_en_i && b.wr_second_en_i && i0 == i1));
    end
  assign b.rs_unused_o = ~valid_q;
  assign b.issue_valid_o = |ready;
  assign b.issue_index_o = sel;
  assign b.issue_payload_o = pl_q[sel];
  assign b.issue_src1_tag_o = t1_q[sel];
  assign b.issue_src2_tag_o = t2_q[sel];
  assign b.rs_count_o = count_q;
endmodule

// File: tb/tb_rs_entry_array.sv
// tb_rs_entry_array: directed steps with an issue-order scoreboard for rs_entry_array.
module tb_rs_entry_array;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  typedef struct { logic [1:0] idx; logic [63:0] pl; } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [1:0] held;
  rs_entry_array_if #(.RS_SIZE(4), .RS_INDEX_WIDTH(2), .TAG_WIDTH(6), .PAYLOAD_WIDTH(64)) bus ();
  rs_entry_array #(.RS_SIZE(4), .RS_INDEX_WIDTH(2), .TAG_WIDTH(6), .PAYLOAD_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .b(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    if (bus.issue_valid_o && bus.issue_ready_i) begin
      if (sb.size() == 0) chk("issue_expected", 64'(sb.size()), 64'd1);
      else begin
        e = sb.pop_front();
        chk("issue_index", 64'(bus.issue_index_o), 64'(e.idx));
        chk("issue_payload", bus.issue_payload_o, e.pl);
      end
    end
    @(posedge clk);
    #1;
    bus.wr_first_en_i = 1'b0;
    bus.wr_second_en_i = 1'b0;
    bus.wakeup_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
  endtask
  task automatic wr0(input logic [1:0] idx, input logic [5:0] t1, input logic r1,
                     input logic [5:0] t2, input logic r2, input logic [63:0] pl);
    bus.wr_first_en_i = 1'b1;
    bus.wr_rs_index_first_i = idx;
    bus.wr_first_src1_tag_i = t1;
    bus.wr_first_src1_rdy_i = r1;
    bus.wr_first_src2_tag_i = t2;
    bus.wr_first_src2_rdy_i = r2;
    bus.wr_first_payload_i = pl;
  endtask
  task automatic wr1(input logic [1:0] idx, input logic [5:0] t1, input logic r1,
                     input logic [5:0] t2, input logic r2, input logic [63:0] pl);
    bus.wr_second_en_i = 1'b1;
    bus.wr_rs_index_second_i = idx;
    bus.wr_second_src1_tag_i = t1;
    bus.wr_second_src1_rdy_i = r1;
    bus.wr_second_src2_tag_i = t2;
    bus.wr_second_src2_rdy_i = r2;
    bus.wr_second_payload_i = pl;
  endtask
  task automatic wake(input logic [5:0] t);
    bus.wakeup_valid_i = 1'b1;
    bus.wakeup_tag_i = t;
  endtask
  initial begin
    bus.flush_i = 0;
    bus.wr_first_en_i = 0;
    bus.wr_second_en_i = 0;
    bus.wakeup_valid_i = 0;
    bus.wakeup_tag_i = 0;
    bus.issue_ready_i = 1;
    wr0(0, 0, 0, 0, 0, 0);
    wr1(0, 0, 0, 0, 0, 0);
    bus.wr_first_en_i = 0;
    bus.wr_second_en_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_unused", 64'(bus.rs_unused_o), 64'hF);
    chk("reset_issue_valid", 64'(bus.issue_valid_o), 64'd0);
    chk("reset_count", 64'(bus.rs_count_o), 64'd0);
    // dual dispatch of ready micro-ops
    wr0(0, 6'h01, 1, 6'h02, 1, 64'hA000_0000_0000_0000);
    wr1(2, 6'h03, 1, 6'h04, 1, 64'hB000_0000_0000_0002);
    sb.push_back('{2'd0, 64'hA000_0000_0000_0000});
    sb.push_back('{2'd2, 64'hB000_0000_0000_0002});
    tick();
    chk("dual_unused", 64'(bus.rs_unused_o), 64'hA);
    chk("dual_count", 64'(bus.rs_count_o), 64'd2);
    chk("dual_valid", 64'(bus.issue_valid_o), 64'd1);
    chk("dual_index0", 64'(bus.issue_index_o), 64'd0);
    tick();
    chk("dual_unused_after0", 64'(bus.rs_unused_o), 64'hB);
    chk("dual_count_after0", 64'(bus.rs_count_o), 64'd1);
    chk("dual_index2", 64'(bus.issue_index_o), 64'd2);
    tick();
    chk("dual_unused_empty", 64'(bus.rs_unused_o), 64'hF);
    chk("dual_count_empty", 64'(bus.rs_count_o), 64'd0);
    chk("dual_valid_empty", 64'(bus.issue_valid_o), 64'd0);
    // delayed wakeup of src1
    wr0(1, 6'h05, 0, 6'h20, 1, 64'hC000_0000_0000_0001);
    sb.push_back('{2'd1, 64'hC000_0000_0000_0001});
    tick();
    chk("wait_valid", 64'(bus.issue_valid_o), 64'd0);
    chk("wait_count", 64'(bus.rs_count_o), 64'd1);
    wake(6'h06);
    tick();
    chk("wrong_tag_valid", 64'(bus.issue_valid_o), 64'd0);
    wake(6'h05);
    tick();
    chk("woken_valid", 64'(bus.issue_valid_o), 64'd1);
    chk("woken_index", 64'(bus.issue_index_o), 64'd1);
    chk("woken_src1_tag", 64'(bus.issue_src1_tag_o), 64'h05);
    chk("woken_src2_tag", 64'(bus.issue_src2_tag_o), 64'h20);
    tick();
    chk("woken_unused", 64'(bus.rs_unused_o), 64'hF);
    // same-cycle bypass on src2
    wr0(3, 6'h10, 1, 6'h11, 0, 64'hD000_0000_0000_0003);
    wake(6'h11);
    sb.push_back('{2'd3, 64'hD000_0000_0000_0003});
    tick();
    chk("bypass_valid", 64'(bus.issue_valid_o), 64'd1);
    chk("bypass_index", 64'(bus.issue_index_o), 64'd3);
    tick();
    chk("bypass_unused", 64'(bus.rs_unused_o), 64'hF);
    // fill, then flush with a wakeup in the same cycle
    wr0(0, 6'h30, 0, 6'h31, 0, 64'h1);
    wr1(1, 6'h32, 0, 6'h33, 0, 64'h2);
    tick();
    wr0(2, 6'h34, 0, 6'h35, 0, 64'h3);
    wr1(3, 6'h36, 0, 6'h30, 0, 64'h4);
    tick();
    chk("full_unused", 64'(bus.rs_unused_o), 64'h0);
    chk("full_count", 64'(bus.rs_count_o), 64'd4);
    chk("full_valid", 64'(bus.issue_valid_o), 64'd0);
    bus.flush_i = 1'b1;
    wake(6'h30);
    tick();
    chk("flush_unused", 64'(bus.rs_unused_o), 64'hF);
    chk("flush_count", 64'(bus.rs_count_o), 64'd0);
    chk("flush_valid", 64'(bus.issue_valid_o), 64'd0);
    wake(6'h31);
    tick();
    chk("post_flush_valid", 64'(bus.issue_valid_o), 64'd0);
    // age versus index order
    wr0(3, 6'h2A, 0, 6'h01, 1, 64'hE000_0000_0000_0003);
    tick();
    wr0(0, 6'h2A, 0, 6'h02, 1, 64'hF000_0000_0000_0000);
    tick();
    chk("age_wait_valid", 64'(bus.issue_valid_o), 64'd0);
    chk("age_count", 64'(bus.rs_count_o), 64'd2);
    bus.issue_ready_i = 1'b0;
    wake(6'h2A);
`ifdef RS_AGE_ORDER_EN
    held = 2'd3;
    sb.push_back('{2'd3, 64'hE000_0000_0000_0003});
    sb.push_back('{2'd0, 64'hF000_0000_0000_0000});
`else
    held = 2'd0;
    sb.push_back('{2'd0, 64'hF000_0000_0000_0000});
    sb.push_back('{2'd3, 64'hE000_0000_0000_0003});
`endif
    tick();
    chk("age_valid", 64'(bus.issue_valid_o), 64'd1);
    chk("age_first_index", 64'(bus.issue_index_o), 64'(held));
    tick();
    chk("stall_index", 64'(bus.issue_index_o), 64'(held));
    chk("stall_count", 64'(bus.rs_count_o), 64'd2);
    bus.issue_ready_i = 1'b1;
    for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("drained_unused", 64'(bus.rs_unused_o), 64'hF);
    // reset in the middle of operation
    wr0(2, 6'h0A, 0, 6'h0B, 0, 64'h5);
    tick();
    chk("pre_reset_unused", 64'(bus.rs_unused_o), 64'hB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_reset_unused", 64'(bus.rs_unused_o), 64'hF);
    chk("mid_reset_count", 64'(bus.rs_count_o), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
